processor_array_seq: RTL

Command sequencer for the head of a `processor_ABCD` systolic chain.
- Accepts one command at a time: opcode, gauss mode and beat count.
- Frames the beats with `start`/`finish`, pulls operand data from a source stream and inserts NOP bubbles when the source stalls.
- Waits for the chain to drain, then reports completion.
- Sits between the top-level scheduler and processor 0: drives its `op_in`, `gauss_op_in`, `start_in`, `finish_in` and `data_in`.

---
 rtl/processor_array_seq_pkg.sv | 41 ++++
 rtl/processor_array_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/processor_array_seq_pkg.sv
// ---------------------------------------------------------------------------
// processor_array_seq_pkg
//   Shared constants for the processor_ABCD chain sequencer:
//   - opcode values understood by every processor in the chain
//   - gauss_op encodings carried alongside each beat
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package processor_array_seq_pkg;

    // Processor opcodes (4-bit native encoding)
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_GAUSS = 4'd1;
    localparam logic [3:0] OP_KEY   = 4'd3;
    localparam logic [3:0] OP_LOADB = 4'd4;
    localparam logic [3:0] OP_SWAPB = 4'd5;
    localparam logic [3:0] OP_MAC   = 4'd6;
    localparam logic [3:0] OP_KMUL  = 4'd7;
    localparam logic [3:0] OP_READ  = 4'd8;
    localparam logic [3:0] OP_ACC   = 4'd9;

    // gauss_op encodings
    localparam logic [1:0] GAUSS_PASS  = 2'b00;
    localparam logic [1:0] GAUSS_MUL   = 2'b01;
    localparam logic [1:0] GAUSS_ADD   = 2'b10;
    localparam logic [1:0] GAUSS_START = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Readout beats carry no operand: they neither consume source data nor
    // forward it.
    function automatic logic is_readout(input logic [3:0] op);
        return (op == OP_READ);
    endfunction

endpackage

// File: rtl/processor_array_seq.sv
// ---------------------------------------------------------------------------
// processor_array_seq
//   Command sequencer at the head of a processor_ABCD systolic chain.
//   Takes one command (opcode, gauss mode, beat count) at a time, issues the
//   beats to processor 0 framed by start/finish, pulls operands from a source
//   stream (NOP bubbles while the source stalls), waits for the chain to
//   drain and then pulses done.
//
// Ports
//   clk, rst            clock / asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op/gauss/len    command fields, latched on acceptance
//   src_valid/ready     operand handshake (ready is a decode of state only)
//   src_data            operand
//   start_out/finish_out/op_out/gauss_op_out/data_out
//                       registered beat stream to processor 0
//   busy                sequencer not idle
//   done                one-cycle completion pulse
// ---------------------------------------------------------------------------
module processor_array_seq
    import processor_array_seq_pkg::*;
#(
    parameter int GF_BIT      = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int LEN_W       = 8,
    parameter int N_PROC      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_CODE_LEN-1:0] cmd_op,
    input  logic [1:0]             cmd_gauss,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [GF_BIT-1:0]      src_data,
    output logic                   start_out,
    output logic                   finish_out,
    output logic [OP_CODE_LEN-1:0] op_out,
    output logic [1:0]             gauss_op_out,
    output logic [GF_BIT-1:0]      data_out,
    output logic                   busy,
    output logic                   done
);

    // Drain wait covers the pipeline depth of the chain plus the output
    // registers at both ends.
    localparam int DRAIN_W = $clog2(N_PROC + 3);

    localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(N_PROC + 2);
    localparam logic [DRAIN_W-1:0]     DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_W-1:0]     DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [LEN_W-1:0]       LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]       LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [OP_CODE_LEN-1:0] OP_NOP_W   = OP_CODE_LEN'(OP_NOP);
    localparam logic [GF_BIT-1:0]      DATA_ZERO  = {GF_BIT{1'b0}};

    // Sequencer state and latched command
    seq_state_e             state_r;
    logic [OP_CODE_LEN-1:0] op_r;
    logic [1:0]             gauss_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       beat_cnt_r;
    logic [DRAIN_W-1:0]     drain_cnt_r;

    // Registered outputs
    logic                   cmd_ready_r;
    logic                   start_r;
    logic                   finish_r;
    logic [OP_CODE_LEN-1:0] op_out_r;
    logic [1:0]             gauss_out_r;
    logic [GF_BIT-1:0]      data_out_r;
    logic                   busy_r;
    logic                   done_r;

    // Beat decode
    logic                   readout_s;
    logic                   issue_s;
    logic                   src_ready_s;
    logic                   beat_s;
    logic                   first_beat_s;
    logic                   last_beat_s;

    // Beat qualification; src_ready depends on state and the latched opcode
    // only, never on src_valid, so the source sees no combinational loop.
    always_comb begin
        readout_s    = is_readout(op_r[3:0]);
        issue_s      = (state_r == ST_ISSUE);
        src_ready_s  = issue_s & ~readout_s;
        beat_s       = issue_s & (readout_s | src_valid);
        first_beat_s = (beat_cnt_r == LEN_ZERO);
        last_beat_s  = (beat_cnt_r == (len_r - LEN_ONE));
    end

    // Sequencer FSM with its beat and drain counters and all registered
    // outputs; every cycle defaults to a NOP bubble toward processor 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP_W;
            gauss_r     <= GAUSS_PASS;
            len_r       <= LEN_ZERO;
            beat_cnt_r  <= LEN_ZERO;
            drain_cnt_r <= DRAIN_ZERO;
            cmd_ready_r <= 1'b1;
            start_r     <= 1'b0;
            finish_r    <= 1'b0;
            op_out_r    <= OP_NOP_W;
            gauss_out_r <= GAUSS_PASS;
            data_out_r  <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            finish_r    <= 1'b0;
            op_out_r    <= OP_NOP_W;
            gauss_out_r <= GAUSS_PASS;
            data_out_r  <= DATA_ZERO;
            done_r      <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r        <= cmd_op;
                        gauss_r     <= cmd_gauss;
                        len_r       <= cmd_len;
                        beat_cnt_r  <= LEN_ZERO;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        // A zero-length command has nothing in the chain to
                        // drain, so it completes straight away.
                        if (cmd_len != LEN_ZERO) begin
                            state_r <= ST_ISSUE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    if (beat_s) begin
                        op_out_r    <= op_r;
                        gauss_out_r <= gauss_r;
                        data_out_r  <= readout_s ? DATA_ZERO : src_data;
                        start_r     <= first_beat_s;
                        finish_r    <= last_beat_s;
                        if (last_beat_s) begin
                            drain_cnt_r <= DRAIN_LOAD;
                            state_r     <= ST_DRAIN;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + LEN_ONE;
                        end
                    end else begin
                        // Stall: bubble already defaulted, beat not counted.
                        beat_cnt_r <= beat_cnt_r;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_ONE) begin
                        drain_cnt_r <= DRAIN_ZERO;
                        state_r     <= ST_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
                    end
                end

                ST_DONE: begin
                    done_r      <= 1'b1;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end

                default: begin
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign src_ready    = src_ready_s;
    assign start_out    = start_r;
    assign finish_out   = finish_r;
    assign op_out       = op_out_r;
    assign gauss_op_out = gauss_out_r;
    assign data_out     = data_out_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule
